// File: rtl/msg_pkg.sv
// Shared widths, character codes and the message ROM for the scrolling display.
package msg_pkg;

    localparam int unsigned MSG_LEN    = 16;
    localparam int unsigned CHAR_W     = 4;
    localparam int unsigned POS_W      = $clog2(MSG_LEN);
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned NUM_DIGITS = 4;

    typedef logic [CHAR_W-1:0] char_t;

    // Slot phase: anodes dark (anti-ghosting) or one digit lit
    typedef enum logic {
        PH_BLANK = 1'b0,
        PH_LIT   = 1'b1
    } phase_t;

    localparam char_t C_0     = 4'd0;
    localparam char_t C_1     = 4'd1;
    localparam char_t C_2     = 4'd2;
    localparam char_t C_3     = 4'd3;
    localparam char_t C_4     = 4'd4;
    localparam char_t C_5     = 4'd5;
    localparam char_t C_6     = 4'd6;
    localparam char_t C_7     = 4'd7;
    localparam char_t C_8     = 4'd8;
    localparam char_t C_9     = 4'd9;
    localparam char_t C_H     = 4'd10;
    localparam char_t C_E     = 4'd11;
    localparam char_t C_L     = 4'd12;
    localparam char_t C_O     = 4'd13;
    localparam char_t C_SPACE = 4'd14;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'b1111111;

    // "HELLO 0123456789"
    localparam char_t MSG_ROM [0:MSG_LEN-1] = '{
        C_H, C_E, C_L, C_L, C_O, C_SPACE, C_0, C_1,
        C_2, C_3, C_4, C_5, C_6, C_7, C_8, C_9
    };

    // ROM index shown on a digit: leftmost digit (3) shows pos, wrapping mod MSG_LEN
    function automatic logic [POS_W-1:0] char_index(input logic [POS_W-1:0] pos,
                                                    input logic [1:0]       digit);
        logic [1:0] offset;
        offset = 2'd3 - digit;
        return pos + POS_W'(offset);
    endfunction

endpackage

// File: rtl/seg_decoder.sv
// Character code to active-low 7-segment pattern, seg_c[6:0] = a..g.
module seg_decoder
    import msg_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  seg_c
);

    // Pattern lookup; unknown codes blank the digit
    always_comb begin
        seg_c = SEG_OFF;
        case (code)
            C_0:     seg_c = 7'b0000001;
            C_1:     seg_c = 7'b1001111;
            C_2:     seg_c = 7'b0010010;
            C_3:     seg_c = 7'b0000110;
            C_4:     seg_c = 7'b1001100;
            C_5:     seg_c = 7'b0100100;
            C_6:     seg_c = 7'b0100000;
            C_7:     seg_c = 7'b0001111;
            C_8:     seg_c = 7'b0000000;
            C_9:     seg_c = 7'b0000100;
            C_H:     seg_c = 7'b1001000;
            C_E:     seg_c = 7'b0110000;
            C_L:     seg_c = 7'b1110001;
            C_O:     seg_c = 7'b0000001;
            C_SPACE: seg_c = SEG_OFF;
            default: seg_c = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/message_scroller.sv
// Scrolls a fixed message across a 4-digit common-anode display, one position per accepted pulse.
module message_scroller
    import msg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV  = 4,
    parameter int unsigned BLANK_CYCLES = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             freeze,
    output logic [3:0]       an,
    output logic [SEG_W-1:0] seg,
    output logic [POS_W-1:0] pos
);

    localparam int unsigned SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;

    logic [SLOT_W-1:0] slot;
    logic [1:0]        digit;
    logic [1:0]        pending;

    logic              slot_last;
    logic              boundary;
    logic              accept;
    logic              consume;
    phase_t            phase;
    logic [1:0]        pending_next;
    logic [POS_W-1:0]  pos_next;
    logic [3:0]        lit_an;
    char_t             char_code;
    logic [SEG_W-1:0]  seg_dec_c;

    // Slot timing, scroll bookkeeping and the character for the current digit
    always_comb begin
        slot_last = (slot == SLOT_W'(REFRESH_DIV - 1));
        boundary  = (slot == '0) && (digit == 2'd3);
        accept    = enable && !freeze;
        consume   = boundary && (pending != 2'd0);
        phase     = (slot < SLOT_W'(BLANK_CYCLES)) ? PH_BLANK : PH_LIT;
        lit_an    = ~(4'b0001 << digit);

        pending_next = pending;
        if (accept && !consume) begin
            if (pending != 2'd3) begin
                pending_next = pending + 2'd1;
            end
        end else if (consume && !accept) begin
            pending_next = pending - 2'd1;
        end

        pos_next  = consume ? pos + POS_W'(1) : pos;
        // Use the post-boundary position so a scroll shows in the same frame it takes effect
        char_code = MSG_ROM[char_index(pos_next, digit)];
    end

    seg_decoder u_seg_decoder (
        .code  (char_code),
        .seg_c (seg_dec_c)
    );

    // Slot/digit sequencer with registered anode, segment and position outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            slot    <= '0;
            digit   <= 2'd3;
            pending <= 2'd0;
            pos     <= '0;
            an      <= 4'b1111;
            seg     <= SEG_OFF;
        end else begin
            slot    <= slot_last ? '0 : slot + SLOT_W'(1);
            if (slot_last) begin
                digit <= digit - 2'd1;
            end
            pending <= pending_next;
            pos     <= pos_next;
            an      <= (phase == PH_BLANK) ? 4'b1111 : lit_an;
            // Segments load during the blank phase so they settle before the anode lights
            if (slot == '0) begin
                seg <= seg_dec_c;
            end
        end
    end

endmodule

// File: tb/tb_message_scroller.sv
// Directed bench for message_scroller: anode sequencing, character window, scroll and reset.
module tb_message_scroller;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       freeze;
    logic [3:0] an;
    logic [6:0] seg;
    logic [3:0] pos;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // Expected active-low patterns for "HELLO 0123456789", indexed by message position
    logic [6:0] exp_seg [0:15] = '{
        7'b1001000, 7'b0110000, 7'b1110001, 7'b1110001,
        7'b0000001, 7'b1111111, 7'b0000001, 7'b1001111,
        7'b0010010, 7'b0000110, 7'b1001100, 7'b0100100,
        7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
    };

    message_scroller dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .freeze (freeze),
        .an     (an),
        .seg    (seg),
        .pos    (pos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h (cyc=%0d)", tag, obs, exp, cyc);
        end
    endtask

    // Anode value expected after edge c counted from reset release (edge 1 is the first blank slot)
    function automatic logic [3:0] exp_an(input int c);
        int s;
        int d;
        logic [3:0] onehot;
        s = (c - 1) % 4;
        d = 3 - (((c - 1) / 4) % 4);
        onehot = 4'b0001 << d;
        return (s == 0) ? 4'b1111 : ~onehot;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance to edge t, checking the anode sequence on every edge
    task automatic run_to(input int t);
        while (cyc < t) begin
            tick();
            cyc++;
            chk("an_seq", 16'(an), 16'(exp_an(cyc)));
        end
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        repeat (n) tick();
        chk("rst_an", 16'(an), 16'h000f);
        chk("rst_seg", 16'(seg), 16'h007f);
        chk("rst_pos", 16'(pos), 16'h0000);
        reset = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse();
        enable = 1'b1;
        tick();
        cyc++;
        chk("an_seq", 16'(an), 16'(exp_an(cyc)));
        enable = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b0;
        freeze = 1'b0;

        // 1: reset state, then first blank and first lit slot
        do_reset(3);
        run_to(1);
        chk("t1_blank_seg", 16'(seg), 16'(exp_seg[0]));
        run_to(2);
        chk("t1_lit_an", 16'(an), 16'h0007);
        chk("t1_lit_seg", 16'(seg), 16'(exp_seg[0]));

        // 2: free run, window "HELL" with pos 0
        for (int c = 3; c <= 34; c++) begin
            run_to(c);
            chk("t2_seg", 16'(seg), 16'(exp_seg[((c - 1) / 4) % 4]));
        end
        chk("t2_pos", 16'(pos), 16'h0000);

        // 3: single pulse at edge 5 moves pos only at the next boundary
        do_reset(1);
        run_to(4);
        pulse();
        run_to(16);
        chk("t3_pos_hold", 16'(pos), 16'h0000);
        run_to(17);
        chk("t3_pos_step", 16'(pos), 16'h0001);
        chk("t3_seg_blank", 16'(seg), 16'(exp_seg[1]));
        run_to(18);
        chk("t3_lit_an", 16'(an), 16'h0007);
        chk("t3_lit_seg", 16'(seg), 16'(exp_seg[1]));

        // 4: four back-to-back pulses saturate pending at 3
        do_reset(1);
        run_to(1);
        pulse(); pulse(); pulse(); pulse();
        run_to(16);
        chk("t4_pos_f0", 16'(pos), 16'h0000);
        run_to(17);
        chk("t4_pos_f1", 16'(pos), 16'h0001);
        run_to(33);
        chk("t4_pos_f2", 16'(pos), 16'h0002);
        run_to(49);
        chk("t4_pos_f3", 16'(pos), 16'h0003);
        run_to(65);
        chk("t4_pos_f4", 16'(pos), 16'h0003);
        run_to(81);
        chk("t4_pos_f5", 16'(pos), 16'h0003);

        // 5: one pulse per frame up to pos 15, window wraps, then pos wraps to 0
        do_reset(1);
        for (int m = 0; m < 15; m++) begin
            run_to(16 * m + 1);
            pulse();
        end
        run_to(240);
        chk("t5_pos_14", 16'(pos), 16'h000e);
        run_to(241);
        chk("t5_pos_15", 16'(pos), 16'h000f);
        run_to(242);
        chk("t5_d3_an", 16'(an), 16'h0007);
        chk("t5_d3_seg", 16'(seg), 16'(exp_seg[15]));
        run_to(246);
        chk("t5_d2_an", 16'(an), 16'h000b);
        chk("t5_d2_seg", 16'(seg), 16'(exp_seg[0]));
        run_to(250);
        chk("t5_d1_an", 16'(an), 16'h000d);
        chk("t5_d1_seg", 16'(seg), 16'(exp_seg[1]));
        run_to(254);
        chk("t5_d0_an", 16'(an), 16'h000e);
        chk("t5_d0_seg", 16'(seg), 16'(exp_seg[2]));
        pulse();
        run_to(256);
        chk("t5_pos_hold", 16'(pos), 16'h000f);
        run_to(257);
        chk("t5_pos_wrap", 16'(pos), 16'h0000);
        run_to(258);
        chk("t5_wrap_seg", 16'(seg), 16'(exp_seg[0]));

        // 6: freeze blocks new pulses but lets a pending one drain
        pulse();
        freeze = 1'b1;
        pulse(); pulse(); pulse(); pulse();
        run_to(272);
        chk("t6_pos_pre", 16'(pos), 16'h0000);
        run_to(273);
        chk("t6_pos_drain", 16'(pos), 16'h0001);
        run_to(289);
        chk("t6_pos_frozen", 16'(pos), 16'h0001);
        freeze = 1'b0;
        pulse(); pulse();
        run_to(295);
        chk("t6_pos_pend", 16'(pos), 16'h0001);

        // Reset with two pulses pending discards them
        do_reset(1);
        run_to(2);
        chk("t6_rst_an", 16'(an), 16'h0007);
        chk("t6_rst_seg", 16'(seg), 16'(exp_seg[0]));
        run_to(17);
        chk("t6_rst_pos1", 16'(pos), 16'h0000);
        run_to(33);
        chk("t6_rst_pos2", 16'(pos), 16'h0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
